flexbus_regbank: RTL

//  Parametrised FlexBus slave register bank for the K-series MCU multiplexed 32-bit AD bus.

---
 rtl/flexbus_regbank_pkg.sv | 21 ++
 rtl/flexbus_regbank_bus_fsm.sv | 101 ++++++++++
 rtl/flexbus_regbank.sv | 93 +++++++++
 3 files changed

// File: rtl/flexbus_regbank_pkg.sv
// Shared definitions for the FlexBus register bank: FSM encodings, RW sense,
// word-offset field position and the value returned for unmapped reads.
package flexbus_regbank_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_DATA = 2'd1,
      ST_DONE = 2'd2
   } fb_state_t;

   localparam logic        FB_RW_READ        = 1'b1;
   localparam logic        FB_RW_WRITE       = 1'b0;
   localparam int          FB_OFF_LSB        = 2;
   localparam int          FB_OFF_MSB        = 9;
   localparam logic [31:0] FB_UNMAPPED_RDATA = 32'h0000_0000;

   function automatic logic fb_base_hit(input logic [31:0] ad, input logic [31:0] base);
      return ad[31:16] == base[31:16];
   endfunction

endpackage

// File: rtl/flexbus_regbank_bus_fsm.sv
// Bus-side sequencer for the FlexBus register bank: tracks ALE/CS/RW, counts
// wait states, and produces the write enable and the read output-enable flop.
//   state | meaning
//   IDLE  | no bus cycle in progress
//   DATA  | address latched, counting CS-low edges towards the data phase
//   DONE  | data phase finished, waiting for CS to rise
module flexbus_regbank_bus_fsm
   import flexbus_regbank_pkg::*;
#(
   parameter int unsigned WAIT_STATES = 1
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_ale,
   input  logic i_cs,
   input  logic i_rw,
   input  logic i_hit,
   output logic o_wr_en,
   output logic o_oe_q
);

   localparam logic [3:0] WS_CNT = 4'(WAIT_STATES);

   fb_state_t  r_state, w_state_nxt;
   logic [3:0] r_cnt, w_cnt_nxt;
   logic       r_rw, w_rw_nxt;
   logic       r_hit, w_hit_nxt;
   logic       r_cs_seen, w_cs_seen_nxt;
   logic       r_oe, w_oe_nxt;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state   <= ST_IDLE;
         r_cnt     <= 4'd0;
         r_rw      <= FB_RW_READ;
         r_hit     <= 1'b0;
         r_cs_seen <= 1'b0;
         r_oe      <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_cnt     <= w_cnt_nxt;
         r_rw      <= w_rw_nxt;
         r_hit     <= w_hit_nxt;
         r_cs_seen <= w_cs_seen_nxt;
         r_oe      <= w_oe_nxt;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_cnt_nxt     = r_cnt;
      w_rw_nxt      = r_rw;
      w_hit_nxt     = r_hit;
      w_cs_seen_nxt = r_cs_seen;
      w_oe_nxt      = r_oe;
      o_wr_en       = 1'b0;
      // ALE restarts from any state and suppresses a write due on the same edge
      if (i_ale) begin
         w_state_nxt   = ST_DATA;
         w_cnt_nxt     = 4'd0;
         w_rw_nxt      = i_rw;
         w_hit_nxt     = i_hit;
         w_cs_seen_nxt = 1'b0;
         w_oe_nxt      = 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               w_oe_nxt = 1'b0;
            end
            ST_DATA: begin
               if (!i_cs) begin
                  w_cs_seen_nxt = 1'b1;
                  if (r_hit && (r_rw == FB_RW_READ)) w_oe_nxt = 1'b1;
                  if (r_cnt == WS_CNT) begin
                     w_state_nxt = ST_DONE;
                     o_wr_en     = r_hit && (r_rw == FB_RW_WRITE);
                  end else begin
                     w_cnt_nxt = r_cnt + 4'd1;
                  end
               end else if (r_cs_seen) begin
                  w_state_nxt = ST_IDLE;
                  w_oe_nxt    = 1'b0;
               end
            end
            ST_DONE: begin
               if (i_cs) begin
                  w_state_nxt = ST_IDLE;
                  w_oe_nxt    = 1'b0;
               end
            end
            default: begin
               w_state_nxt = ST_IDLE;
               w_oe_nxt    = 1'b0;
            end
         endcase
      end
   end

   assign o_oe_q = r_oe;

endmodule

// File: rtl/flexbus_regbank.sv
// FlexBus slave register bank: N_RW control registers, N_RO status registers,
// read-back on the multiplexed AD bus and one-cycle per-register write strobes.
module flexbus_regbank
   import flexbus_regbank_pkg::*;
#(
   parameter logic [31:0]        FB_BASE     = 32'h6000_0000,
   parameter int unsigned        N_RW        = 5,
   parameter int unsigned        N_RO        = 2,
   parameter int unsigned        WAIT_STATES = 1,
   parameter logic [N_RW*32-1:0] RST_VALS    = '0
) (
   input  logic                                FB_CLK,
   input  logic                                RST_n,
   input  logic                                FB_ALE,
   input  logic                                FB_CS,
   input  logic                                FB_RW,
   inout  wire  [31:0]                         FB_AD,
   output logic [N_RW*32-1:0]                  REG_Qout,
   output logic [N_RW-1:0]                     REG_WR_Pulse,
   input  logic [((N_RO > 0) ? N_RO : 1)*32-1:0] STAT_Din
);

   localparam logic [7:0] N_RW_OFF = 8'(N_RW);

   logic [N_RW-1:0][31:0] r_regs;
   logic [N_RW-1:0]       r_pulse;
   logic [7:0]            r_off;
   logic [31:0]           r_rdata;
   logic [7:0]            w_off_in;
   logic [31:0]           w_rd_snap;
   logic                  w_hit;
   logic                  w_wr_en;
   logic                  w_we;
   logic                  w_oe_q;
   logic                  w_drive;

   flexbus_regbank_bus_fsm #(
      .WAIT_STATES (WAIT_STATES)
   ) u_bus_fsm (
      .i_clk   (FB_CLK),
      .i_rst_n (RST_n),
      .i_ale   (FB_ALE),
      .i_cs    (FB_CS),
      .i_rw    (FB_RW),
      .i_hit   (w_hit),
      .o_wr_en (w_wr_en),
      .o_oe_q  (w_oe_q)
   );

   assign w_hit    = fb_base_hit(FB_AD, FB_BASE);
   assign w_off_in = FB_AD[FB_OFF_MSB:FB_OFF_LSB];

   // Read data is taken at the ALE edge, so status reads return that snapshot
   always_comb begin
      w_rd_snap = FB_UNMAPPED_RDATA;
      for (int i = 0; i < N_RW; i++) begin
         if (w_off_in == 8'(i)) w_rd_snap = r_regs[i];
      end
      for (int j = 0; j < N_RO; j++) begin
         if (w_off_in == 8'(N_RW + j)) w_rd_snap = STAT_Din[32*j +: 32];
      end
   end

   assign w_we = w_wr_en && (r_off < N_RW_OFF);

   always_ff @(posedge FB_CLK or negedge RST_n) begin
      if (!RST_n) begin
         r_regs  <= RST_VALS;
         r_pulse <= '0;
         r_off   <= 8'd0;
         r_rdata <= FB_UNMAPPED_RDATA;
      end else begin
         r_pulse <= '0;
         if (FB_ALE) begin
            r_off   <= w_off_in;
            r_rdata <= w_rd_snap;
         end
         for (int i = 0; i < N_RW; i++) begin
            if (w_we && (r_off == 8'(i))) begin
               r_regs[i]  <= FB_AD;
               r_pulse[i] <= 1'b1;
            end
         end
      end
   end

   // CS rising or a new ALE releases the bus without waiting for a clock edge
   assign w_drive      = w_oe_q & ~FB_CS & ~FB_ALE;
   assign FB_AD        = w_drive ? r_rdata : 32'bz;
   assign REG_Qout     = r_regs;
   assign REG_WR_Pulse = r_pulse;

endmodule
